// File: rtl/sdi_key_loader.sv
// Purpose: streams LDKEY instruction, KEY segment header and two-share key words onto an SDI port.
// Latency: first word valid the cycle after start; one word per sdi_valid&&sdi_ready; done one cycle after the last word.
// Backpressure: sdi_data/sdi_valid hold while !sdi_ready; outputs are registered. Macro SDI_KEY_MASK_EN masks the key shares.
module sdi_key_loader #(
    parameter int       BUSW      = 32,
    parameter int       KEYW      = 128,
    parameter bit [3:0] LDKEY_OPC = 4'h4,
    parameter bit [3:0] KEY_TYPE  = 4'hC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KEYW-1:0] key,
    input  logic [31:0]     rnd_data,
    output logic            busy,
    output logic            done,
    output logic [BUSW-1:0] sdi_data,
    output logic            sdi_valid,
    input  logic            sdi_ready
);

    localparam int NW = KEYW / 32;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    // Elaboration guards: the datapath is built for 32-bit words only.
    if (BUSW != 32) begin : g_busw_chk
        $error("sdi_key_loader: BUSW must be 32");
    end
    if ((KEYW < 32) || ((KEYW % 32) != 0)) begin : g_keyw_chk
        $error("sdi_key_loader: KEYW must be a non-zero multiple of 32");
    end

    localparam logic [31:0] INSTR_WORD = {LDKEY_OPC, 28'h0};
    // Flags 4'h2 marks the key segment as the last segment of the instruction.
    localparam logic [31:0] HDR_WORD   = {KEY_TYPE, 4'h2, 8'h00, 16'(KEYW / 8)};
    localparam logic [WW-1:0] W_LAST   = WW'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_HDR,
        S_SH0,
        S_SH1,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   w_q, w_d;
    logic [KEYW-1:0] key_q, key_d;
    logic [31:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            xfer;
    logic            w_last;
    int              sel_idx;
    logic [31:0]     key_word;
    logic [31:0]     share0;
    logic [31:0]     share1;

    // MSB word of the key is word 0.
    function automatic logic [31:0] get_word(input logic [KEYW-1:0] k, input int idx);
        return k[KEYW-1-32*idx -: 32];
    endfunction

`ifdef SDI_KEY_MASK_EN
    logic [31:0] mask_q, mask_d;
`else
    // Randomness is only consumed by the masked build.
    logic rnd_unused;
    assign rnd_unused = ^rnd_data;
`endif

    // Select which key word the next share0 is built from and form both shares.
    always_comb begin
        xfer     = valid_q && sdi_ready;
        w_last   = (w_q == W_LAST);
        sel_idx  = 0;
        if ((state_q == S_SH1) && !w_last) begin
            sel_idx = int'(w_q) + 1;
        end
        key_word = get_word(key_q, sel_idx);
`ifdef SDI_KEY_MASK_EN
        share0   = key_word ^ rnd_data;
        share1   = mask_q;
`else
        share0   = key_word;
        share1   = 32'h0;
`endif
    end

    // Next-state and output-register logic; every register holds unless a transfer advances it.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        key_d   = key_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SDI_KEY_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    data_d  = INSTR_WORD;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_INSTR;
                end
            end
            S_INSTR: begin
                if (xfer) begin
                    data_d  = HDR_WORD;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    w_d     = '0;
                    data_d  = share0;
`ifdef SDI_KEY_MASK_EN
                    mask_d  = rnd_data;
`endif
                    state_d = S_SH0;
                end
            end
            S_SH0: begin
                if (xfer) begin
                    data_d  = share1;
                    state_d = S_SH1;
                end
            end
            S_SH1: begin
                if (xfer) begin
                    if (w_last) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        w_d     = w_q + 1'b1;
                        data_d  = share0;
`ifdef SDI_KEY_MASK_EN
                        mask_d  = rnd_data;
`endif
                        state_d = S_SH0;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any stream in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            key_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SDI_KEY_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            key_q   <= key_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SDI_KEY_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign sdi_data  = data_q;
    assign sdi_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sdi_key_loader.sv
// Purpose: directed self-checking bench for sdi_key_loader (KEYW=128 and KEYW=256 instances).
// Latency: expects first word the cycle after start and done one cycle after the final transfer.
// Backpressure: drives sdi_ready constant or pseudo-random and checks data holds through stalls.
module tb_sdi_key_loader;

`ifdef SDI_KEY_MASK_EN
    localparam logic [31:0] MASK = 32'hA5A5A5A5;
`else
    localparam logic [31:0] MASK = 32'h0;
`endif

    localparam logic [127:0] KA = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [255:0] KB =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [127:0] key_a;
    logic [255:0] key_b;
    logic [31:0]  rnd;
    logic         rdy;
    logic         busy_a, done_a, valid_a;
    logic         busy_b, done_b, valid_b;
    logic [31:0]  data_a, data_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_q[$];
    int busy_cnt, done_cnt, done_at, last_xfer, stall_err;

    always #5 clk = ~clk;

    sdi_key_loader #(.BUSW(32), .KEYW(128)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key_a), .rnd_data(rnd),
        .busy(busy_a), .done(done_a), .sdi_data(data_a), .sdi_valid(valid_a),
        .sdi_ready(rdy)
    );

    sdi_key_loader #(.BUSW(32), .KEYW(256)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b), .rnd_data(rnd),
        .busy(busy_b), .done(done_b), .sdi_data(data_b), .sdi_valid(valid_b),
        .sdi_ready(rdy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected i-th word of a stream for key k of kbits bits.
    function automatic logic [31:0] exp_word(input logic [255:0] k, input int kbits, input int i);
        int j;
        int w;
        logic [31:0] kw;
        if (i == 0) return 32'h40000000;
        if (i == 1) return {4'hC, 4'h2, 8'h00, 16'(kbits / 8)};
        j  = i - 2;
        w  = j / 2;
        kw = k[kbits-1-32*w -: 32];
        return ((j % 2) == 0) ? (kw ^ MASK) : MASK;
    endfunction

    task automatic cmp_stream(input string tag, input logic [255:0] k, input int kbits);
        int n;
        n = 2 + 2 * (kbits / 32);
        check({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD_0000_0000_0000,
                  64'(exp_word(k, kbits, i)));
        end
    endtask

    // Runs one stream cycle by cycle, sampling on the falling edge.
    // repulse_at: re-assert start with an all-ones key once that many words have gone.
    // abort_at: assert rst once that many words have gone and end the run.
    task automatic collect(input bit sel, input bit rand_rdy, input int repulse_at, input int abort_at);
        logic        v, bz, dn, stalled;
        logic [31:0] d, held;
        int          rp;
        rp = repulse_at;
        got_q.delete();
        busy_cnt = 0; done_cnt = 0; done_at = -1; last_xfer = -1; stall_err = 0;
        stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            v  = sel ? valid_b : valid_a;
            d  = sel ? data_b  : data_a;
            bz = sel ? busy_b  : busy_a;
            dn = sel ? done_b  : done_a;
            if (bz) busy_cnt++;
            if (dn) begin
                done_cnt++;
                done_at = cyc;
            end
            if (stalled && (d != held)) stall_err++;
            if ((abort_at >= 0) && (got_q.size() == abort_at)) begin
                rst = 1'b1;
                #1;
                check("abort_valid", 64'(valid_a), 64'(0));
                check("abort_busy", 64'(busy_a), 64'(0));
                check("abort_done", 64'(done_a), 64'(0));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if ((rp >= 0) && (got_q.size() == rp) && v) begin
                start_a = 1'b1;
                key_a   = '1;
                rp      = -1;
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && rdy) begin
                got_q.push_back(d);
                last_xfer = cyc;
            end
            stalled = v && !rdy;
            held    = d;
            if ((cyc > 0) && !bz) break;
        end
        check("run_completed", 64'(sel ? busy_b : busy_a), 64'(0));
    endtask

    initial begin
        logic [31:0] exp1 [10];
        exp1 = '{32'h40000000, 32'hC2000010,
                 32'h00010203 ^ MASK, MASK, 32'h04050607 ^ MASK, MASK,
                 32'h08090A0B ^ MASK, MASK, 32'h0C0D0E0F ^ MASK, MASK};
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        key_a = '0; key_b = '0; rnd = 32'hA5A5A5A5; rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(valid_a), 64'(0));
        check("rst_data", 64'(data_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));

        // Reference stream with sdi_ready held high.
        start_a = 1'b1; key_a = KA;
        collect(1'b0, 1'b0, -1, -1);
        check("t1_count", 64'(got_q.size()), 64'(10));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_w%0d", i),
                  (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD_0000_0000_0000, 64'(exp1[i]));
        end
        check("t1_done_pulses", 64'(done_cnt), 64'(1));
        check("t1_done_timing", 64'(done_at), 64'(last_xfer + 1));
        // Window counted from the cycle start is presented through the last busy cycle.
        check("t1_busy_window", 64'(busy_cnt + 1), 64'(12));
        check("t1_idle_valid", 64'(valid_a), 64'(0));
        if (got_q.size() == 10) begin
            for (int w = 0; w < 4; w++) begin
                check($sformatf("t1_xor%0d", w), 64'(got_q[2+2*w] ^ got_q[3+2*w]),
                      64'(KA[127-32*w -: 32]));
            end
        end

        // Random backpressure.
        start_a = 1'b1; key_a = KA;
        collect(1'b0, 1'b1, -1, -1);
        cmp_stream("t2", {128'h0, KA}, 128);
        check("t2_stall_hold", 64'(stall_err), 64'(0));
        check("t2_done_timing", 64'(done_at), 64'(last_xfer + 1));

        // start while busy is ignored; the follow-up start uses the new key.
        start_a = 1'b1; key_a = KA;
        collect(1'b0, 1'b0, 4, -1);
        cmp_stream("t3", {128'h0, KA}, 128);
        start_a = 1'b1; key_a = '1;
        collect(1'b0, 1'b0, -1, -1);
        cmp_stream("t3_ones", {128'h0, {128{1'b1}}}, 128);

        // Reset during SH1 of word 2, then a clean restart.
        start_a = 1'b1; key_a = KA;
        collect(1'b0, 1'b0, -1, 7);
        start_a = 1'b1; key_a = KA;
        collect(1'b0, 1'b0, -1, -1);
        check("t4_first", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hDEAD, 64'h40000000);
        check("t4_count", 64'(got_q.size()), 64'(10));

        // 256-bit key instance.
        start_b = 1'b1; key_b = KB;
        collect(1'b1, 1'b0, -1, -1);
        cmp_stream("t5", KB, 256);
        check("t5_hdr", (got_q.size() > 1) ? 64'(got_q[1]) : 64'hDEAD, 64'hC2000020);
        check("t5_done_timing", 64'(done_at), 64'(last_xfer + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
